// File: rtl/game_menu_sel.sv
// Level-select / pay-to-play menu controller: PS/2 key decode, credit debit
// handshake, level launch, and downscaled background-image pixel address.
module game_menu_sel #(
  parameter int unsigned NUM_LEVELS  = 4,
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned MONEY_W     = 7,
  parameter int unsigned COST_BASE   = 10,
  parameter int unsigned COST_STEP   = 5,
  parameter int unsigned TICKET_LVL  = 1,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               keydown,
  input  logic               ready,
  input  logic [8:0]         last_change,
  input  logic [MONEY_W-1:0] money,
  input  logic               debit_ack,
  input  logic               game_over,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic [LVL_W-1:0]   cursor,
  output logic [LVL_W-1:0]   level,
  output logic               ticket,
  output logic               debit_valid,
  output logic [MONEY_W-1:0] debit_amt,
  output logic               start,
  output logic               deny
);

  localparam logic [3:0]       MAX_DIGIT = 4'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LVL_HELP  = LVL_W'(NUM_LEVELS + 1);
  localparam logic [LVL_W-1:0] LVL_TKT   = LVL_W'(TICKET_LVL);

  typedef enum logic [1:0] {S_MENU, S_HELP, S_DEBIT, S_PLAY} state_t;

  state_t             state, state_n;
  logic               prev, evt_q;
  logic [8:0]         code_q;
  logic               key_evt;
  logic [LVL_W-1:0]   lvl_q, lvl_n;
  logic [LVL_W-1:0]   cursor_n, level_n;
  logic               ticket_n, debit_valid_n, start_n, deny_n;
  logic [MONEY_W-1:0] debit_amt_n, cost_c;
  logic [3:0]         digit;
  logic               k_up, k_down, k_enter, k_help, k_esc;

  assign key_evt = keydown & ready & ~prev;
  assign cost_c  = MONEY_W'(COST_BASE + COST_STEP * (32'(cursor) - 32'd1));

  // Edge-detect and register the key; only MENU/HELP ever consume it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= 1'b0;
      evt_q  <= 1'b0;
      code_q <= '0;
    end else begin
      prev   <= keydown & ready;
      evt_q  <= key_evt & ((state == S_MENU) | (state == S_HELP));
      code_q <= last_change;
    end
  end

  // Scan-code decode
  always_comb begin
    digit   = 4'd0;
    k_up    = 1'b0;
    k_down  = 1'b0;
    k_enter = 1'b0;
    k_help  = 1'b0;
    k_esc   = 1'b0;
    case (code_q)
      9'h016: digit = 4'd1;
      9'h01E: digit = 4'd2;
      9'h026: digit = 4'd3;
      9'h025: digit = 4'd4;
      9'h02E: digit = 4'd5;
      9'h036: digit = 4'd6;
      9'h03D: digit = 4'd7;
      9'h03E: digit = 4'd8;
      9'h046: digit = 4'd9;
      9'h175: k_up    = 1'b1;
      9'h172: k_down  = 1'b1;
      9'h05A: k_enter = 1'b1;
      9'h04A: k_help  = 1'b1;
      9'h076: k_esc   = 1'b1;
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    cursor_n      = cursor;
    level_n       = level;
    ticket_n      = ticket;
    debit_valid_n = debit_valid;
    debit_amt_n   = debit_amt;
    lvl_n         = lvl_q;
    start_n       = 1'b0;
    deny_n        = 1'b0;
    case (state)
      S_MENU: begin
        level_n = '0;
        if (evt_q) begin
          if (digit != 4'd0 && digit <= MAX_DIGIT) begin
            cursor_n = LVL_W'(digit);
          end else if (k_up) begin
            cursor_n = (cursor == LVL_ONE) ? LVL_LAST : cursor - LVL_ONE;
          end else if (k_down) begin
            cursor_n = (cursor == LVL_LAST) ? LVL_ONE : cursor + LVL_ONE;
          end else if (k_help) begin
            state_n = S_HELP;
            level_n = LVL_HELP;
          end else if (k_enter) begin
            if (money >= cost_c) begin
              state_n       = S_DEBIT;
              debit_valid_n = 1'b1;
              debit_amt_n   = cost_c;
              lvl_n         = cursor;
            end else begin
              deny_n = 1'b1;
            end
          end
        end
      end
      S_HELP: begin
        if (evt_q && (k_esc || k_help)) begin
          state_n = S_MENU;
          level_n = '0;
        end
      end
      S_DEBIT: begin
        if (debit_ack) begin
          state_n       = S_PLAY;
          debit_valid_n = 1'b0;
          start_n       = 1'b1;
          level_n       = lvl_q;
          ticket_n      = (lvl_q == LVL_TKT);
        end
      end
      S_PLAY: begin
        if (game_over) begin
          state_n  = S_MENU;
          level_n  = '0;
          ticket_n = 1'b0;
        end
      end
      default: state_n = S_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_MENU;
      cursor      <= LVL_ONE;
      level       <= '0;
      ticket      <= 1'b0;
      debit_valid <= 1'b0;
      debit_amt   <= '0;
      start       <= 1'b0;
      deny        <= 1'b0;
      lvl_q       <= LVL_ONE;
    end else begin
      state       <= state_n;
      cursor      <= cursor_n;
      level       <= level_n;
      ticket      <= ticket_n;
      debit_valid <= debit_valid_n;
      debit_amt   <= debit_amt_n;
      start       <= start_n;
      deny        <= deny_n;
      lvl_q       <= lvl_n;
    end
  end

  // Background image address, free-running in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel_addr <= '0;
    else     pixel_addr <= ADDR_W'(32'(h_cnt >> SCALE_SHIFT) + IMG_W * 32'(v_cnt >> SCALE_SHIFT));
  end

endmodule
